// File: rtl/md_ctrl_if.sv
// E-stage multiply/divide port bundle shared by the pipeline and md_ctrl.
// The pipeline side is the master, md_ctrl is the slave.
interface md_ctrl_if;
    logic [3:0]  md_op;
    logic        e_hold;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_D;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rdata;
    logic        md_stall_D;

    modport master (
        output md_op, e_hold, rs_val, rt_val, md_use_D,
        input  start, busy, hi, lo, md_rdata, md_stall_D
    );

    modport slave (
        input  md_op, e_hold, rs_val, rt_val, md_use_D,
        output start, busy, hi, lo, md_rdata, md_stall_D
    );
endinterface

// File: rtl/md_ctrl.sv
// Multi-cycle MULT/DIV controller owning HI/LO. The result is computed at issue,
// held in shadow registers and committed to HI/LO when the busy counter expires.
module md_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    md_ctrl_if.slave md
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     hi_q, lo_q;
    logic [31:0]     sh_hi_q, sh_lo_q;
    logic            sh_ok_q;
    logic            commit;

    logic            is_muldiv;
    logic            is_mul;
    logic            idle;
    logic            mt_hi_we, mt_lo_we;

    logic [31:0]     res_hi, res_lo;
    logic            res_ok;
    logic [63:0]     prod_s, prod_u;
    logic            div_zero, div_ovf;
    logic [31:0]     divs, divu;
    logic [31:0]     q_s, r_s, q_u, r_u;

    assign idle      = (state_q == IDLE);
    assign is_muldiv = (md.md_op >= OP_MULT) && (md.md_op <= OP_DIVU);
    assign is_mul    = (md.md_op == OP_MULT) || (md.md_op == OP_MULTU);
    assign mt_hi_we  = (md.md_op == OP_MTHI) && !md.e_hold && idle;
    assign mt_lo_we  = (md.md_op == OP_MTLO) && !md.e_hold && idle;

    assign md.start      = is_muldiv && !md.e_hold && idle;
    assign md.busy       = !idle;
    assign md.hi         = hi_q;
    assign md.lo         = lo_q;
    assign md.md_stall_D = md.md_use_D && (md.start || md.busy);

    // Zero divisor and the MIN/-1 overflow both divide by 1 instead; for the
    // overflow case that yields exactly the architected result (q=MIN, r=0).
    assign prod_s   = $signed({{32{md.rs_val[31]}}, md.rs_val}) * $signed({{32{md.rt_val[31]}}, md.rt_val});
    assign prod_u   = {32'd0, md.rs_val} * {32'd0, md.rt_val};
    assign div_zero = (md.rt_val == 32'd0);
    assign div_ovf  = (md.rs_val == 32'h8000_0000) && (md.rt_val == 32'hFFFF_FFFF);
    assign divs     = (div_zero || div_ovf) ? 32'd1 : md.rt_val;
    assign divu     = div_zero ? 32'd1 : md.rt_val;
    assign q_s      = $signed(md.rs_val) / $signed(divs);
    assign r_s      = $signed(md.rs_val) % $signed(divs);
    assign q_u      = md.rs_val / divu;
    assign r_u      = md.rs_val % divu;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_ok = 1'b1;
        case (md.md_op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV:   begin res_lo = q_s; res_hi = r_s; res_ok = !div_zero; end
            OP_DIVU:  begin res_lo = q_u; res_hi = r_u; res_ok = !div_zero; end
            default:  ;
        endcase
    end

    always_comb begin
        md.md_rdata = 32'd0;
        if (md.md_op == OP_MFHI)      md.md_rdata = hi_q;
        else if (md.md_op == OP_MFLO) md.md_rdata = lo_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: if (md.start) begin
                state_d = RUN;
                cnt_d   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    commit  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_hi_q <= 32'd0;
            sh_lo_q <= 32'd0;
            sh_ok_q <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (md.start) begin
                sh_hi_q <= res_hi;
                sh_lo_q <= res_lo;
                sh_ok_q <= res_ok;
            end
            if (commit && sh_ok_q) begin
                hi_q <= sh_hi_q;
                lo_q <= sh_lo_q;
            end else begin
                if (mt_hi_we) hi_q <= md.rs_val;
                if (mt_lo_we) lo_q <= md.rs_val;
            end
        end
    end

    // The hazard unit must keep any md op that issues or writes out of E while busy.
    a_no_op_while_busy: assert property (@(posedge clk) disable iff (reset)
        !(state_q == RUN && md.md_op >= OP_MULT && md.md_op <= OP_MTLO));

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: table of mul/div vectors plus hand sequences for
// reset, hold, MT/MF, stall and back-to-back corners.
module tb_md_ctrl;

    localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    md_ctrl_if mif ();

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          n;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs just after the rising edge, return at the falling edge for sampling.
    task automatic cyc(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic hold, input logic use_d);
        @(posedge clk);
        #1;
        mif.md_op    = op;
        mif.rs_val   = rs;
        mif.rt_val   = rt;
        mif.e_hold   = hold;
        mif.md_use_D = use_d;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{MULT,  32'hFFFF_FFFF, 32'h0000_0002,  5, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{MULTU, 32'hFFFF_FFFF, 32'h0000_0002,  5, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{DIVU,  32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003};
        vecs[4] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{MULT,  32'h0000_0003, 32'h0000_0004,  5, 32'h0000_0000, 32'h0000_000C};
        vecs[6] = '{DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 10, 32'h0000_0001, 32'h7FFF_FFFC};
        vecs[7] = '{DIV,   32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};

        reset        = 1'b1;
        mif.md_op    = NONE;
        mif.rs_val   = 32'd0;
        mif.rt_val   = 32'd0;
        mif.e_hold   = 1'b0;
        mif.md_use_D = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, mif.busy}, 32'd0);
        check("reset_hi", mif.hi, 32'd0);
        check("reset_lo", mif.lo, 32'd0);
        check("reset_start", {31'd0, mif.start}, 32'd0);

        // Table: issue, N busy cycles with scrambled operands, then result visible in cycle N+1.
        for (int i = 0; i < 8; i++) begin
            cyc(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0, 1'b0);
            check($sformatf("v%0d_start", i), {31'd0, mif.start}, 32'd1);
            for (int k = 1; k <= vecs[i].n; k++) begin
                cyc(NONE, 32'hDEAD_0000 + k, 32'h0000_BEEF, 1'b0, 1'b0);
                if (mif.busy !== 1'b1)
                    check($sformatf("v%0d_busy_c%0d", i, k), {31'd0, mif.busy}, 32'd1);
            end
            checks++;
            cyc(MFLO, 32'd0, 32'd0, 1'b0, 1'b0);
            check($sformatf("v%0d_idle", i), {31'd0, mif.busy}, 32'd0);
            check($sformatf("v%0d_hi", i), mif.hi, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), mif.lo, vecs[i].exp_lo);
            check($sformatf("v%0d_mflo", i), mif.md_rdata, vecs[i].exp_lo);
        end

        // Divide by zero keeps prior HI/LO but still runs the full latency.
        cyc(MTHI, 32'h0000_000A, 32'd0, 1'b0, 1'b0);
        cyc(MTLO, 32'h0000_000B, 32'd0, 1'b0, 1'b0);
        cyc(DIV, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0);
        check("dz_start", {31'd0, mif.start}, 32'd1);
        check("dz_mt_hi", mif.hi, 32'h0000_000A);
        check("dz_mt_lo", mif.lo, 32'h0000_000B);
        for (int k = 1; k <= 10; k++) cyc(NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        check("dz_busy_c10", {31'd0, mif.busy}, 32'd1);
        cyc(NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        check("dz_idle_c11", {31'd0, mif.busy}, 32'd0);
        check("dz_hi", mif.hi, 32'h0000_000A);
        check("dz_lo", mif.lo, 32'h0000_000B);

        // MTHI under e_hold is suppressed, then takes effect once released.
        cyc(MTHI, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
        cyc(MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        check("mthi_hold_hi", mif.hi, 32'h0000_000A);
        cyc(MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
        check("mthi_hi", mif.hi, 32'h1234_5678);
        check("mfhi_rdata", mif.md_rdata, 32'h1234_5678);
        check("mthi_busy", {31'd0, mif.busy}, 32'd0);
        cyc(MFLO, 32'd0, 32'd0, 1'b0, 1'b0);
        check("mflo_rdata", mif.md_rdata, 32'h0000_000B);
        cyc(NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        check("none_rdata", mif.md_rdata, 32'd0);

        // MULT held in E does not issue until e_hold drops.
        cyc(MULT, 32'd6, 32'd7, 1'b1, 1'b0);
        check("hold_start0", {31'd0, mif.start}, 32'd0);
        cyc(MULT, 32'd6, 32'd7, 1'b1, 1'b0);
        check("hold_busy1", {31'd0, mif.busy}, 32'd0);
        cyc(MULT, 32'd6, 32'd7, 1'b0, 1'b0);
        check("hold_start2", {31'd0, mif.start}, 32'd1);
        for (int k = 1; k <= 5; k++) cyc(NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        check("hold_busy_last", {31'd0, mif.busy}, 32'd1);
        cyc(NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        check("hold_lo", mif.lo, 32'd42);
        check("hold_hi", mif.hi, 32'd0);

        // MFLO waiting in D is stalled for the start cycle plus all busy cycles.
        cyc(DIV, 32'd100, 32'd7, 1'b0, 1'b1);
        check("stall_c0", {31'd0, mif.md_stall_D}, 32'd1);
        for (int k = 1; k <= 11; k++) begin
            cyc(NONE, 32'd0, 32'd0, 1'b0, 1'b1);
            check($sformatf("stall_c%0d", k), {31'd0, mif.md_stall_D}, (k <= 10) ? 32'd1 : 32'd0);
        end
        cyc(MFLO, 32'd0, 32'd0, 1'b0, 1'b0);
        check("stall_mflo", mif.md_rdata, 32'd14);
        check("stall_hi", mif.hi, 32'd2);
        check("stall_released", {31'd0, mif.md_stall_D}, 32'd0);

        // Back-to-back: second op issues in the cycle after busy falls.
        cyc(MULT, 32'd2, 32'd3, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) cyc(NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(MULTU, 32'd5, 32'd5, 1'b0, 1'b0);
        check("b2b_start", {31'd0, mif.start}, 32'd1);
        check("b2b_first_lo", mif.lo, 32'd6);
        for (int k = 1; k <= 5; k++) cyc(NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        check("b2b_second_lo", mif.lo, 32'd25);
        check("b2b_second_hi", mif.hi, 32'd0);

        // Async reset in the middle of a MULT discards the pending result.
        cyc(MULT, 32'd3, 32'd4, 1'b0, 1'b0);
        cyc(NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        check("rst_mid_busy_pre", {31'd0, mif.busy}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, mif.busy}, 32'd0);
        check("rst_mid_hi", mif.hi, 32'd0);
        check("rst_mid_lo", mif.lo, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 6; k++) cyc(NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        check("rst_mid_no_commit_lo", mif.lo, 32'd0);
        check("rst_mid_no_commit_busy", {31'd0, mif.busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
